// File: rtl/aes_pkg.sv
// Shared AES datapath types and the default word/block geometry used by the
// word packer.
package aes_pkg;

  localparam int AES_WORD_W          = 32;
  localparam int AES_WORDS_PER_BLOCK = 4;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] block_t;

  typedef enum logic {
    OBUF_EMPTY = 1'b0,
    OBUF_FULL  = 1'b1
  } obuf_state_e;

endpackage

// File: rtl/word_packer_obuf.sv
// Output holding register for the word packer: one block plus its partial flag,
// handed to the consumer with a valid/ready handshake.
module word_packer_obuf
  import aes_pkg::*;
#(
  parameter int OUT_W = 128
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [OUT_W-1:0] load_data,
  input  logic             load_partial,
  input  logic             out_ready,
  output logic             can_load,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  output logic             out_partial
);

  obuf_state_e      state_q, state_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic             partial_q, partial_d;

  // A load may land on the same edge that the consumer takes the old block.
  assign can_load = (state_q == OBUF_EMPTY) || out_ready;

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    partial_d = partial_q;
    if (load) begin
      state_d   = OBUF_FULL;
      data_d    = load_data;
      partial_d = load_partial;
    end else if ((state_q == OBUF_FULL) && out_ready) begin
      state_d = OBUF_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= OBUF_EMPTY;
      data_q    <= '0;
      partial_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      partial_q <= partial_d;
    end
  end

  assign out_data    = data_q;
  assign out_valid   = (state_q == OBUF_FULL);
  assign out_partial = partial_q;

endmodule

// File: rtl/word_packer.sv
// Packs RATIO words of IN_W bits into one OUT_W-bit block, with a zero-padded
// flush for partial blocks and a double buffer towards the consumer.
module word_packer
  import aes_pkg::*;
#(
  parameter int IN_W      = AES_WORD_W,
  parameter int RATIO     = AES_WORDS_PER_BLOCK,
  parameter bit MSB_FIRST = 1'b1,
  localparam int OUT_W    = IN_W * RATIO,
  localparam int CNT_W    = $clog2(RATIO + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_partial,
  output logic [CNT_W-1:0] fill_cnt
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RATIO);

  logic [OUT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flush_pend_q, flush_pend_d;

  logic             accept;
  logic [OUT_W-1:0] acc_w;
  logic [CNT_W-1:0] cnt_w;
  logic [OUT_W-1:0] padded;
  int unsigned      pad_sh;
  logic             full_now;
  logic             flush_req;
  logic             can_load;
  logic             xfer_full;
  logic             xfer_part;
  logic             load;
  logic [OUT_W-1:0] load_data;

  // Depends on registered state only, so no path from out_ready to in_ready.
  assign in_ready = (cnt_q < FULL_CNT) && !flush_pend_q;
  assign accept   = in_valid && in_ready;

  always_comb begin
    acc_w = acc_q;
    if (accept) begin
      if (MSB_FIRST) acc_w = {acc_q[OUT_W-IN_W-1:0], in_data};
      else           acc_w = {in_data, acc_q[OUT_W-1:IN_W]};
    end
    cnt_w = cnt_q + {{(CNT_W-1){1'b0}}, accept};

    // Align a partial block as though zero words filled the empty slots.
    pad_sh = (RATIO - int'(cnt_w)) * IN_W;
    if (MSB_FIRST) padded = acc_w << pad_sh;
    else           padded = acc_w >> pad_sh;

    full_now  = (cnt_w == FULL_CNT);
    flush_req = (flush || flush_pend_q) && (cnt_w != '0) && !full_now;
    xfer_full = full_now && can_load;
    xfer_part = flush_req && can_load;
    load      = xfer_full || xfer_part;
    load_data = xfer_full ? acc_w : padded;

    acc_d        = acc_w;
    cnt_d        = cnt_w;
    flush_pend_d = flush_req && !can_load;
    if (load) begin
      acc_d        = '0;
      cnt_d        = '0;
      flush_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (cnt_q <= FULL_CNT);
    end
  end

  word_packer_obuf #(
    .OUT_W(OUT_W)
  ) u_obuf (
    .clk         (clk),
    .reset_n     (reset_n),
    .load        (load),
    .load_data   (load_data),
    .load_partial(xfer_part),
    .out_ready   (out_ready),
    .can_load    (can_load),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_partial (out_partial)
  );

  assign fill_cnt = cnt_q;

endmodule
